// File: rtl/comparator_pkg.sv
// Shared types for the sequential magnitude comparator: FSM states, chunk verdicts
// and the count-width helper.
package comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RES_LT = 2'd0,
    RES_EQ = 2'd1,
    RES_GT = 2'd2
  } res_t;

  // Count must hold NCHUNK itself, hence one bit more than the index.
  function automatic int cw_calc(input int nchunk);
    return $clog2(nchunk) + 1;
  endfunction

endpackage

// File: rtl/comparator_chunk.sv
// Combinational CHUNK-bit magnitude cell producing a single gt/eq/lt verdict.
module comparator_chunk
  import comparator_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output res_t             res
);

  always_comb begin
    res = RES_EQ;
    if (a > b)
      res = RES_GT;
    else if (a < b)
      res = RES_LT;
  end

endmodule

// File: rtl/comparator_nb_seq.sv
// Multi-cycle N-bit magnitude comparator, MSB chunk first with early exit.
// Define SIGNED_CMP_EN for a two's-complement compare; unsigned otherwise.
module comparator_nb_seq
  import comparator_pkg::*;
#(
  parameter  int WIDTH  = 16,
  parameter  int CHUNK  = 4,
  localparam int NCHUNK = WIDTH / CHUNK,
  localparam int CW     = cw_calc(WIDTH / CHUNK)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_great_b,
  output logic             a_equal_b,
  output logic             a_less_b,
  output logic [CW-1:0]    cmp_cycles
);

  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

`ifdef SIGNED_CMP_EN
  // Flipping both sign bits maps two's-complement order onto unsigned order.
  localparam logic [WIDTH-1:0] MSB_FLIP = {1'b1, {(WIDTH-1){1'b0}}};
`else
  localparam logic [WIDTH-1:0] MSB_FLIP = '0;
`endif

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [IW-1:0]    idx_reg;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic             pend_reg, last_reg;
  logic [CHUNK-1:0] chunk_a_reg, chunk_b_reg;
  logic             a_great_b_reg, a_equal_b_reg, a_less_b_reg;
  logic [CW-1:0]    cmp_cycles_reg;
  res_t             cell_res;

  logic [CHUNK-1:0] a_chunks [NCHUNK];
  logic [CHUNK-1:0] b_chunks [NCHUNK];

  genvar gi;
  generate
    for (gi = 0; gi < NCHUNK; gi++) begin : g_chunk
      assign a_chunks[gi] = a_reg[gi*CHUNK +: CHUNK];
      assign b_chunks[gi] = b_reg[gi*CHUNK +: CHUNK];
    end
  endgenerate

  // The selected chunk pair is registered so the wide mux and the compare
  // cell sit in separate cycles; the decision trails idx by one cycle.
  comparator_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a   (chunk_a_reg),
    .b   (chunk_b_reg),
    .res (cell_res)
  );

  assign count_next = count_reg + CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      a_reg          <= '0;
      b_reg          <= '0;
      idx_reg        <= '0;
      count_reg      <= '0;
      pend_reg       <= 1'b0;
      last_reg       <= 1'b0;
      chunk_a_reg    <= '0;
      chunk_b_reg    <= '0;
      a_great_b_reg  <= 1'b0;
      a_equal_b_reg  <= 1'b0;
      a_less_b_reg   <= 1'b0;
      cmp_cycles_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a ^ MSB_FLIP;
            b_reg     <= b ^ MSB_FLIP;
            idx_reg   <= IW'(NCHUNK - 1);
            count_reg <= '0;
            pend_reg  <= 1'b0;
            last_reg  <= 1'b0;
            state_reg <= CMP;
          end
        end
        CMP: begin
          chunk_a_reg <= a_chunks[idx_reg];
          chunk_b_reg <= b_chunks[idx_reg];
          pend_reg    <= 1'b1;
          last_reg    <= (idx_reg == '0);
          if (idx_reg != '0)
            idx_reg <= idx_reg - IW'(1);
          if (pend_reg) begin
            count_reg <= count_next;
            if (cell_res != RES_EQ || last_reg) begin
              a_great_b_reg  <= (cell_res == RES_GT);
              a_equal_b_reg  <= (cell_res == RES_EQ);
              a_less_b_reg   <= (cell_res == RES_LT);
              cmp_cycles_reg <= count_next;
              state_reg      <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            a_great_b_reg  <= 1'b0;
            a_equal_b_reg  <= 1'b0;
            a_less_b_reg   <= 1'b0;
            cmp_cycles_reg <= '0;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state_reg == IDLE);
  assign out_valid  = (state_reg == DONE);
  assign a_great_b  = a_great_b_reg;
  assign a_equal_b  = a_equal_b_reg;
  assign a_less_b   = a_less_b_reg;
  assign cmp_cycles = cmp_cycles_reg;

endmodule
